// File: rtl/sort_datapath_if.sv
// Control and host bundle between the exchange-sort controller/host and sort_datapath.
// master drives strobes and host writes; slave is the datapath that returns flags and read data.
interface sort_datapath_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
);
   logic              Li, Lj, Ei, Ej;
   logic              EA, EB;
   logic              WR, Csel, Bout;
   logic              zi, zj, AgtB;
   logic              host_sel, host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic [DATA_W-1:0] host_rdata;
   logic [CNT_W-1:0]  swap_cnt;

   modport master (
      output Li, Lj, Ei, Ej, EA, EB, WR, Csel, Bout,
      output host_sel, host_we, host_addr, host_wdata,
      input  zi, zj, AgtB, host_rdata, swap_cnt
   );

   modport slave (
      input  Li, Lj, Ei, Ej, EA, EB, WR, Csel, Bout,
      input  host_sel, host_we, host_addr, host_wdata,
      output zi, zj, AgtB, host_rdata, swap_cnt
   );
endinterface

// File: rtl/sort_datapath.sv
// Exchange-sort datapath: element memory, index counters i/j, operand registers A/B,
// comparator and swap counter, with a host port for loading and reading back data.
module sort_datapath #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   sort_datapath_if.slave   bus
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] i, j;
   logic [DATA_W-1:0] a, b;
   logic [CNT_W-1:0]  cnt;

   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_ctrl;
   logic [DATA_W-1:0] rd_host;

   // host_sel owns only the memory write port; A/B loads always use the controller address
   always_comb begin
      addr      = bus.Csel ? j : i;
      mem_addr  = bus.host_sel ? bus.host_addr : addr;
      mem_we    = bus.host_sel ? bus.host_we : bus.WR;
      mem_wdata = bus.host_sel ? bus.host_wdata : (bus.Bout ? b : a);
   end

   // addresses at or beyond DEPTH match no entry: reads give 0, writes are dropped
   always_comb begin
      rd_ctrl = '0;
      rd_host = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (addr == ADDR_W'(k))          rd_ctrl = mem[k];
         if (bus.host_addr == ADDR_W'(k)) rd_host = mem[k];
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (mem_we && (mem_addr == ADDR_W'(k))) mem[k] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i   <= '0;
         j   <= '0;
         a   <= '0;
         b   <= '0;
         cnt <= '0;
      end else begin
         if (bus.Li)      i <= '0;
         else if (bus.Ei) i <= i + ADDR_W'(1);

         // j follows the pre-edge i even when i itself moves this cycle
         if (bus.Lj)      j <= i + ADDR_W'(1);
         else if (bus.Ej) j <= j + ADDR_W'(1);

         if (bus.EA) a <= rd_ctrl;
         if (bus.EB) b <= rd_ctrl;

         if (bus.Li)
            cnt <= '0;
         else if (bus.WR && bus.Bout && !bus.host_sel && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.zi         = (i == ADDR_W'(DEPTH-2));
   assign bus.zj         = (j == ADDR_W'(DEPTH-1));
   assign bus.AgtB       = (a > b);
   assign bus.host_rdata = rd_host;
   assign bus.swap_cnt   = cnt;

endmodule

// File: tb/tb_sort_datapath.sv
// Bench for sort_datapath: an 8-entry instance with a 4-bit index (out-of-range cases)
// checked every cycle against a behavioural model, and a 4-entry instance driven as a sorter.
module tb_sort_datapath;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sort_datapath_if #(.DATA_W(8), .ADDR_W(4), .CNT_W(8)) b8 ();
   sort_datapath_if #(.DATA_W(8), .ADDR_W(2), .CNT_W(8)) b4 ();

   sort_datapath #(.DATA_W(8), .DEPTH(8), .ADDR_W(4), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .bus(b8)
   );
   sort_datapath #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .CNT_W(8)) dut4 (
      .clk(clk), .rst(rst), .bus(b4)
   );

   localparam bit [8:0] LI  = 9'h100, LJ  = 9'h080, EI  = 9'h040, EJ = 9'h020;
   localparam bit [8:0] SEA = 9'h010, SEB = 9'h008, SWR = 9'h004;
   localparam bit [8:0] CS  = 9'h002, BO  = 9'h001;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the 8-entry instance ----------------
   int m_i = 0, m_j = 0, m_a = 0, m_b = 0, m_cnt = 0;
   int m_mem [16];

   function automatic int m_rd(input int ad);
      return (ad < 8) ? m_mem[ad] : 0;
   endfunction

   function automatic int m_caddr();
      return b8.Csel ? m_j : m_i;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_i <= 0; m_j <= 0; m_a <= 0; m_b <= 0; m_cnt <= 0;
      end else begin
         if (b8.Li)      m_i <= 0;
         else if (b8.Ei) m_i <= (m_i + 1) % 16;
         if (b8.Lj)      m_j <= (m_i + 1) % 16;
         else if (b8.Ej) m_j <= (m_j + 1) % 16;
         if (b8.EA) m_a <= m_rd(m_caddr());
         if (b8.EB) m_b <= m_rd(m_caddr());
         if (b8.host_sel) begin
            if (b8.host_we && b8.host_addr < 8) m_mem[b8.host_addr] <= int'(b8.host_wdata);
         end else if (b8.WR && m_caddr() < 8) begin
            m_mem[m_caddr()] <= b8.Bout ? m_b : m_a;
         end
         if (b8.Li) m_cnt <= 0;
         else if (b8.WR && b8.Bout && !b8.host_sel) m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         chk("zi",         b8.zi,         (m_i == 6) ? 1 : 0);
         chk("zj",         b8.zj,         (m_j == 7) ? 1 : 0);
         chk("AgtB",       b8.AgtB,       (m_a > m_b) ? 1 : 0);
         chk("host_rdata", b8.host_rdata, m_rd(int'(b8.host_addr)));
         chk("swap_cnt",   b8.swap_cnt,   m_cnt);
         chk("i",          dut8.i,        m_i);
         chk("j",          dut8.j,        m_j);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic ctl(input int which, input bit [8:0] s);
      if (which == 8) begin
         {b8.Li, b8.Lj, b8.Ei, b8.Ej, b8.EA, b8.EB, b8.WR, b8.Csel, b8.Bout} = s;
      end else begin
         {b4.Li, b4.Lj, b4.Ei, b4.Ej, b4.EA, b4.EB, b4.WR, b4.Csel, b4.Bout} = s;
      end
      @(posedge clk); #1;
      {b8.Li, b8.Lj, b8.Ei, b8.Ej, b8.EA, b8.EB, b8.WR, b8.Csel, b8.Bout} = '0;
      {b4.Li, b4.Lj, b4.Ei, b4.Ej, b4.EA, b4.EB, b4.WR, b4.Csel, b4.Bout} = '0;
   endtask

   task automatic hw8(input int ad, input int d);
      b8.host_sel = 1'b1; b8.host_we = 1'b1;
      b8.host_addr = 4'(ad); b8.host_wdata = 8'(d);
      @(posedge clk); #1;
      b8.host_sel = 1'b0; b8.host_we = 1'b0;
   endtask

   task automatic hw4(input int ad, input int d);
      b4.host_sel = 1'b1; b4.host_we = 1'b1;
      b4.host_addr = 2'(ad); b4.host_wdata = 8'(d);
      @(posedge clk); #1;
      b4.host_sel = 1'b0; b4.host_we = 1'b0;
   endtask

   // exchange-sort sequencing as the controller would issue it
   task automatic run_sort4(output bit finished, output int cnt_after_li);
      int n;
      finished = 1'b0;
      n = 0;
      ctl(4, LI);
      cnt_after_li = int'(b4.swap_cnt);
      ctl(4, LJ);
      while (!finished && n < 400) begin
         ctl(4, SEA);
         ctl(4, SEB | CS);
         n += 2;
         if (b4.AgtB) begin
            ctl(4, SWR | BO);
            ctl(4, SWR | CS);
         end
         if (b4.zj) begin
            if (b4.zi) finished = 1'b1;
            else begin
               ctl(4, EI);
               ctl(4, LJ);
            end
         end else begin
            ctl(4, EJ);
         end
      end
   endtask

   initial begin
      bit   fin;
      int   after_li;
      int   sw [4];
      int   exp_swaps;
      int   t;

      {b8.Li, b8.Lj, b8.Ei, b8.Ej, b8.EA, b8.EB, b8.WR, b8.Csel, b8.Bout} = '0;
      {b4.Li, b4.Lj, b4.Ei, b4.Ej, b4.EA, b4.EB, b4.WR, b4.Csel, b4.Bout} = '0;
      b8.host_sel = 0; b8.host_we = 0; b8.host_addr = '0; b8.host_wdata = '0;
      b4.host_sel = 0; b4.host_we = 0; b4.host_addr = '0; b4.host_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int k = 0; k < 8; k++) hw8(k, 0);
      chk_on = 1'b1;

      // host load / readback, out-of-range host writes
      hw8(3, 8'hA5);
      hw8(9, 8'h00);
      hw8(9, 8'h5A);
      b8.host_addr = 4'd3; #1 chk("host_rd3", b8.host_rdata, 8'hA5);
      b8.host_addr = 4'd9; #1 chk("host_rd9", b8.host_rdata, 0);
      b8.host_addr = 4'd1; #1 chk("host_rd1_noalias", b8.host_rdata, 0);
      b8.host_we = 1'b1; b8.host_addr = 4'd2; b8.host_wdata = 8'hFF;
      @(posedge clk); #1 b8.host_we = 1'b0;
      chk("host_we_no_sel", b8.host_rdata, 0);

      // counter priority
      ctl(8, EI); ctl(8, LI | EI);
      chk("li_over_ei", dut8.i, 0);
      ctl(8, EI); ctl(8, EI);
      ctl(8, LJ | EJ);
      chk("lj_over_ej", dut8.j, 3);
      repeat (4) ctl(8, EI);
      chk("zi_at_6", b8.zi, 1);
      ctl(8, LJ);
      chk("j_7", dut8.j, 7);
      chk("zj_at_7", b8.zj, 1);
      ctl(8, EJ);
      ctl(8, LI | LJ);
      chk("lj_old_i_j", dut8.j, 7);
      chk("lj_old_i_i", dut8.i, 0);

      // swap step on [3,1]
      hw8(0, 3); hw8(1, 1);
      ctl(8, LI); ctl(8, LJ);
      ctl(8, SEA);
      chk("A_3", dut8.a, 3);
      ctl(8, SEB | CS);
      chk("B_1", dut8.b, 1);
      chk("AgtB_1", b8.AgtB, 1);
      ctl(8, SWR | BO);
      ctl(8, SWR | CS);
      b8.host_addr = 4'd0; #1 chk("mem0_1", b8.host_rdata, 1);
      b8.host_addr = 4'd1; #1 chk("mem1_3", b8.host_rdata, 3);
      chk("swap_cnt_1", b8.swap_cnt, 1);

      // host_sel blocks controller writes and swap counting
      hw8(0, 8'h77);
      b8.host_sel = 1'b1; b8.host_addr = 4'd5;
      ctl(8, SWR | BO);
      b8.host_sel = 1'b0;
      b8.host_addr = 4'd0; #1 chk("host_sel_blocks_wr", b8.host_rdata, 8'h77);
      chk("host_sel_no_count", b8.swap_cnt, 1);

      // out-of-range counter address, then wrap
      ctl(8, LI);
      repeat (9) ctl(8, EI);
      ctl(8, SWR);
      ctl(8, SEA);
      chk("oor_read_A", dut8.a, 0);
      repeat (7) ctl(8, EI);
      chk("i_wrap", dut8.i, 0);

      // saturation
      ctl(8, LI);
      repeat (260) ctl(8, SWR | BO);
      chk("swap_sat", b8.swap_cnt, 255);
      ctl(8, LI);
      chk("li_clears_cnt", b8.swap_cnt, 0);

      // asynchronous reset between edges; memory survives
      hw8(5, 8'h3C);
      ctl(8, EI); ctl(8, LJ); ctl(8, SEA); ctl(8, SEB | CS); ctl(8, SWR | BO);
      #2 rst = 1'b1;
      #1;
      chk("rst_i", dut8.i, 0);
      chk("rst_j", dut8.j, 0);
      chk("rst_A", dut8.a, 0);
      chk("rst_B", dut8.b, 0);
      chk("rst_cnt", b8.swap_cnt, 0);
      chk("rst_zj", b8.zj, 0);
      @(negedge clk); #1 rst = 1'b0;
      b8.host_addr = 4'd5; #1 chk("mem_survives_rst", b8.host_rdata, 8'h3C);

      // integration as a sorter, DEPTH=4
      sw = '{3, 1, 2, 0};
      for (int k = 0; k < 4; k++) hw4(k, sw[k]);
      exp_swaps = 0;
      for (int x = 0; x < 3; x++)
         for (int y = x + 1; y < 4; y++)
            if (sw[x] > sw[y]) begin
               t = sw[x]; sw[x] = sw[y]; sw[y] = t;
               exp_swaps++;
            end
      run_sort4(fin, after_li);
      chk("sort1_done", fin, 1);
      chk("sort1_swaps_lit", b4.swap_cnt, 5);
      chk("sort1_swaps_model", b4.swap_cnt, exp_swaps);
      for (int k = 0; k < 4; k++) begin
         b4.host_addr = 2'(k); #1;
         chk("sort1_mem_lit", b4.host_rdata, k);
         chk("sort1_mem_model", b4.host_rdata, sw[k]);
      end
      run_sort4(fin, after_li);
      chk("sort2_done", fin, 1);
      chk("sort2_cnt_after_li", after_li, 0);
      chk("sort2_swaps", b4.swap_cnt, 0);
      for (int k = 0; k < 4; k++) begin
         b4.host_addr = 2'(k); #1;
         chk("sort2_mem", b4.host_rdata, k);
      end

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sort_datapath.md
Name: sort_datapath

Overview:
- Datapath that carries out the control strobes of the exchange-sort controller: Li/Lj/Ei/Ej, EA/EB, WR/Csel/Bout.
- Holds the element memory, index counters i and j, operand registers A and B, and the comparator.
- Returns status flags zi, zj and AgtB to the controller.
- Host port loads unsorted data before a sort and reads sorted data after done.
- Counts swaps performed in the current sort.

Parameters:
- DATA_W, 8, element width in bits (unsigned).
- DEPTH, 8, number of elements; minimum 2.
- ADDR_W, 3, index width; must satisfy 2^ADDR_W >= DEPTH.
- CNT_W, 8, swap counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Li  in  1  load i <= 0.
- Lj  in  1  load j <= i+1.
- Ei  in  1  increment i.
- Ej  in  1  increment j.
- EA  in  1  A <= mem[addr].
- EB  in  1  B <= mem[addr].
- WR  in  1  controller write mem[addr].
- Csel  in  1  address select: 0 = i, 1 = j.
- Bout  in  1  write data select: 1 = B, 0 = A.
- zi  out  1  i == DEPTH-2.
- zj  out  1  j == DEPTH-1.
- AgtB  out  1  A > B, unsigned.
- host_sel  in  1  1 = host owns the memory port.
- host_we  in  1  host write strobe.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  mem[host_addr], combinational.
- swap_cnt  out  CNT_W  swaps in the current sort.

Behaviour:
- Reset (async, immediate): i=0, j=0, A=0, B=0, swap_cnt=0.
  - Memory is not reset; contents survive rst.
  - Derived outputs after reset: zi = (DEPTH==2), zj = 0, AgtB = 0.
- Memory: DEPTH x DATA_W register array, combinational read, synchronous write on clk rising edge.
  - addr = Csel ? j : i, used when host_sel=0.
- Counter i:
  - Li has priority over Ei.
  - Li: i <= 0.
  - Ei (without Li): i <= i+1, wraps modulo 2^ADDR_W, no guard.
- Counter j:
  - Lj has priority over Ej.
  - Lj: j <= i+1 (current i, pre-edge), modulo 2^ADDR_W.
  - Ej (without Lj): j <= j+1.
- i and j updates may occur in the same cycle. Lj uses the old i, even if Li or Ei is also asserted.
- Registers A and B: EA loads A <= mem[addr] and EB loads B <= mem[addr] at the edge. Both may assert together and load the same word.
- Controller write: WR loads mem[addr] <= (Bout ? B : A) at the edge, only when host_sel=0.
- Flags zi, zj and AgtB are purely combinational from i, j, A and B: no added latency, valid the cycle after the load edge.
- Swap counter:
  - Li clears swap_cnt to 0 (priority over increment).
  - A cycle with WR=1, Bout=1, host_sel=0 increments swap_cnt.
  - Saturates at 2^CNT_W-1.
- Host port:
  - host_sel=1 and host_we=1 writes mem[host_addr] <= host_wdata.
  - host_sel=1 forces controller WR to be ignored.
  - EA/EB/Li/Lj/Ei/Ej still act; host_sel gates the memory port only.
  - host_we is ignored when host_sel=0.
  - host_rdata is always mem[host_addr], regardless of host_sel.
- Out-of-range address (>= DEPTH, from host or counter):
  - Writes are dropped.
  - Reads return 0.
- rst mid-sort: counters and registers clear immediately. Memory keeps partially sorted data; no recovery is attempted.

Test Plan:
- Reset: assert rst asynchronously between edges -> i, j, A, B and swap_cnt read 0 before the next edge. A word written via the host beforehand is still readable.
- Host load/readback with DEPTH=8: host writes 8'hA5 to addr 3 and 8'h00 to addr 9 (use ADDR_W=4 for this case). Read addr 3 -> 8'hA5; read addr 9 -> 0, no write took effect.
- Counter priority:
  - Li and Ei together -> i=0.
  - With i=2, Lj and Ej together -> j=3.
  - With i=6, DEPTH=8 -> zi=1; Lj then gives j=7 and zj=1.
- Swap step, memory [3,1]:
  - Csel=0 EA -> A=3.
  - Csel=1 EB -> B=1; AgtB=1.
  - WR Csel=0 Bout=1 -> mem[0]=1.
  - WR Csel=1 Bout=0 -> mem[1]=3.
  - swap_cnt=1.
- Integration with the controller, DEPTH=4, load [3,1,2,0], pulse start -> at done memory = [0,1,2,3] and swap_cnt = 5. A second start clears swap_cnt to 0 on Li; the sort ends with 0 swaps.
- host_sel=1 during a controller WR -> memory unchanged by the controller, and swap_cnt does not increment.
